// File: rtl/pcileech_fifo_pack.sv
// Packs up to seven 32-bit words plus a status word into one 256-bit packet for a wide FIFO.
// Latency: packet presented one cycle after the 7th accept, or after a flush/idle timeout; din is stalled while a packet is pending.
module pcileech_fifo_pack #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  din,
    input  logic [1:0]   din_type,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         flush,
    output logic [255:0] dout,
    output logic         wr_en,
    input  logic         almost_full,
    output logic [31:0]  pkt_count
);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;
    localparam logic [2:0]  LAST_SLOT = 3'd6;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [6:0][31:0] slots_q, slots_d;
    logic [13:0]      types_q, types_d;
    logic [6:0]       mask_q, mask_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;

    logic accept;
    logic emit;
    logic timeout_hit;

    assign accept      = (state_q == FILL) & din_valid;
    assign emit        = (state_q == PEND) & ~almost_full;
    assign timeout_hit = (tmr_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        slots_d   = slots_q;
        types_d   = types_q;
        mask_d    = mask_q;
        pkt_cnt_d = pkt_cnt_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    // An accept always wins over a coincident flush or timeout.
                    for (int i = 0; i < 7; i++) begin
                        if (cnt_q == 3'(i)) begin
                            slots_d[i]        = din;
                            types_d[2*i +: 2] = din_type;
                            mask_d[i]         = 1'b1;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                    tmr_d = 16'd0;
                    if (cnt_q == LAST_SLOT) begin
                        state_d = PEND;
                    end
                end else if (cnt_q == 3'd0) begin
                    tmr_d = 16'd0;
                end else if (flush || timeout_hit) begin
                    state_d = PEND;
                    tmr_d   = 16'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            PEND: begin
                tmr_d = 16'd0;
                if (emit) begin
                    state_d   = FILL;
                    cnt_d     = 3'd0;
                    slots_d   = '0;
                    types_d   = '0;
                    mask_d    = '0;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= 3'd0;
            tmr_q     <= 16'd0;
            slots_q   <= '0;
            types_q   <= '0;
            mask_q    <= '0;
            pkt_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            slots_q   <= slots_d;
            types_q   <= types_d;
            mask_q    <= mask_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    assign din_ready = (state_q == FILL) & ~rst;
    assign wr_en     = emit & ~rst;
    assign dout      = rst ? 256'd0 : {4'hE, 7'd0, mask_q, types_q, slots_q};
    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_pcileech_fifo_pack.sv
// Directed bench for pcileech_fifo_pack with TIMEOUT=4.
module tb_pcileech_fifo_pack;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  din;
    logic [1:0]   din_type;
    logic         din_valid;
    logic         din_ready;
    logic         flush;
    logic [255:0] dout;
    logic         wr_en;
    logic         almost_full;
    logic [31:0]  pkt_count;

    int n_chk  = 0;
    int n_pass = 0;

    int           wr_cnt = 0;
    int           dbl_cnt = 0;
    logic         prev_wr = 1'b0;
    logic [255:0] pkt_q[$];

    pcileech_fifo_pack #(.TIMEOUT(16'd4)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_type    (din_type),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .flush       (flush),
        .dout        (dout),
        .wr_en       (wr_en),
        .almost_full (almost_full),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt = wr_cnt + 1;
            pkt_q.push_back(dout);
            if (prev_wr) dbl_cnt = dbl_cnt + 1;
        end
        prev_wr = wr_en;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] t);
        din       = d;
        din_type  = t;
        din_valid = 1'b1;
        step();
    endtask

    initial begin
        int           k;
        int           wr0;
        int           iter;
        logic         acc;
        logic [255:0] exp;
        logic [255:0] got;

        rst = 1'b1; din = '0; din_type = '0; din_valid = 1'b0;
        flush = 1'b0; almost_full = 1'b0;
        step();
        step();
        chk("rst_din_ready", 256'(din_ready), 256'd0);
        chk("rst_wr_en", 256'(wr_en), 256'd0);
        chk("rst_dout", dout, 256'd0);
        chk("rst_pkt_count", 256'(pkt_count), 256'd0);
        rst = 1'b0;
        step();
        chk("idle_din_ready", 256'(din_ready), 256'd1);

        // Full packet, words 1..7 type 01
        for (int i = 1; i <= 7; i++) send(32'(i), 2'b01);
        din_valid = 1'b0;
        chk("full_wr_en", 256'(wr_en), 256'd1);
        chk("full_din_ready", 256'(din_ready), 256'd0);
        chk("full_dout", dout,
            256'hE01FD555_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        step();
        chk("full_wr_en_drop", 256'(wr_en), 256'd0);
        chk("full_pkt_count", 256'(pkt_count), 256'd1);
        chk("full_pulses", 256'(wr_cnt), 256'd1);

        // Three words then idle: timeout after four idle cycles
        send(32'hA, 2'b11);
        send(32'hB, 2'b10);
        send(32'hC, 2'b01);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_idle%0d", i), 256'(wr_en), 256'd0);
            step();
        end
        chk("tmo_wr_en", 256'(wr_en), 256'd1);
        chk("tmo_dout", dout,
            256'hE001C01B_00000000_00000000_00000000_00000000_0000000C_0000000B_0000000A);
        step();
        chk("tmo_pkt_count", 256'(pkt_count), 256'd2);

        // Back-pressure held for 20 cycles with din_valid kept high
        almost_full = 1'b1;
        for (int i = 0; i < 7; i++) send(32'h11 + 32'(i), 2'b00);
        din = 32'hDEAD;
        wr0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("af_hold%0d", i), 256'({din_ready, wr_en}), 256'd0);
            step();
        end
        din_valid = 1'b0;
        chk("af_no_pulse", 256'(wr_cnt - wr0), 256'd0);
        almost_full = 1'b0;
        #1;
        chk("af_release_wr_en", 256'(wr_en), 256'd1);
        chk("af_dout", dout,
            256'hE01FC000_00000017_00000016_00000015_00000014_00000013_00000012_00000011);
        step();
        chk("af_one_pulse", 256'(wr_cnt - wr0), 256'd1);
        chk("af_pkt_count", 256'(pkt_count), 256'd3);

        // Flush on an empty packer does nothing
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush_empty%0d", i), 256'(wr_en), 256'd0);
        end
        flush = 1'b0;
        chk("flush_empty_pkt", 256'(pkt_count), 256'd3);

        // Flush coincident with the 2nd accept is ignored
        send(32'h21, 2'b01);
        flush = 1'b1;
        send(32'h22, 2'b10);
        flush = 1'b0;
        din_valid = 1'b0;
        chk("flush_coinc0", 256'(wr_en), 256'd0);
        step();
        chk("flush_coinc1", 256'(wr_en), 256'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_late_wr_en", 256'(wr_en), 256'd1);
        chk("flush_late_dout", dout,
            256'hE000C009_00000000_00000000_00000000_00000000_00000000_00000022_00000021);
        step();
        chk("flush_pkt_count", 256'(pkt_count), 256'd4);

        // Reset mid-fill discards the partial packet
        wr0 = wr_cnt;
        for (int i = 0; i < 5; i++) send(32'h40 + 32'(i), 2'b10);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_dout_now", dout, 256'd0);
        step();
        chk("midrst_outs", 256'({din_ready, wr_en}), 256'd0);
        chk("midrst_pkt_count", 256'(pkt_count), 256'd0);
        rst = 1'b0;
        step();
        step();
        chk("midrst_no_write", 256'(wr_cnt - wr0), 256'd0);
        for (int i = 0; i < 7; i++) send(32'h31 + 32'(i), 2'b11);
        din_valid = 1'b0;
        chk("postrst_dout", dout,
            256'hE01FFFFF_00000037_00000036_00000035_00000034_00000033_00000032_00000031);
        step();
        chk("postrst_pkt_count", 256'(pkt_count), 256'd1);

        // 70 words with din_valid held continuously
        pkt_q.delete();
        wr0 = wr_cnt;
        k = 0;
        iter = 0;
        din_valid = 1'b1;
        while (k < 70 && iter < 200) begin
            din      = 32'h100 + 32'(k);
            din_type = 2'(k % 4);
            acc      = din_ready;
            step();
            if (acc) k = k + 1;
            iter = iter + 1;
        end
        din_valid = 1'b0;
        chk("stream_all_accepted", 256'(k), 256'd70);
        chk("stream_cycles", 256'(iter), 256'd79);
        step();
        step();
        chk("stream_pkts", 256'(pkt_q.size()), 256'd10);
        chk("stream_pulses", 256'(wr_cnt - wr0), 256'd10);
        for (int p = 0; p < 10; p++) begin
            exp = '0;
            exp[255:252] = 4'hE;
            exp[20+224:14+224] = 7'h7F;
            for (int i = 0; i < 7; i++) begin
                exp[32*i +: 32]        = 32'h100 + 32'(7*p + i);
                exp[224 + 2*i +: 2]    = 2'((7*p + i) % 4);
            end
            got = (p < pkt_q.size()) ? pkt_q[p] : 256'd0;
            chk($sformatf("stream_pkt%0d", p), got, exp);
        end
        chk("stream_pkt_count", 256'(pkt_count), 256'd11);
        chk("single_cycle_pulses", 256'(dbl_cnt), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pcileech_fifo_pack.md
PCILEECH_FIFO_PACK -- requirements
Module: pcileech_fifo_pack

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024: idle cycles before a partial packet is flushed; legal range 1..65535.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 din  in  32  data word to pack.
REQ-005 din_type  in  2  word type tag, carried into the status word.
REQ-006 din_valid  in  1  din/din_type valid.
REQ-007 din_ready  out  1  packer accepts; transfer occurs when din_valid&din_ready at posedge clk.
REQ-008 flush  in  1  request early emission of a partial packet.
REQ-009 dout  out  256  packed word to the downstream 256-bit FIFO din.
REQ-010 wr_en  out  1  dout valid; downstream writes on this cycle.
REQ-011 almost_full  in  1  downstream back-pressure.
REQ-012 pkt_count  out  32  number of packets written since reset.

Function
REQ-013 The block SHALL pack up to 7 data words plus 1 status word into one 256-bit packet.
REQ-014 Slot i (i=0..6) SHALL occupy dout[32i+31:32i], filled in arrival order starting at slot 0.
REQ-015 The status word dout[255:224] SHALL be: [13:0] slot types (2 bits/slot, slot i at [2i+1:2i]); [20:14] valid mask (bit 14+i = slot i filled); [27:21] 0; [31:28] 4'hE.
REQ-016 Unfilled slots, and the type bits of unfilled slots, SHALL read as zero.
REQ-017 The block SHALL have two states: FILL and PEND.
REQ-018 In FILL, din_ready SHALL be 1; in PEND, din_ready SHALL be 0.
REQ-019 FILL->PEND SHALL occur when the 7th word is accepted.
REQ-020 FILL->PEND SHALL occur when the word count is 1..6 and either flush=1 or the idle timer reaches TIMEOUT-1, provided no word is accepted that cycle.
REQ-021 If a word is accepted in the same cycle as flush, the word SHALL be accepted and the flush SHALL be ignored.
REQ-022 Flush or timeout with word count 0 SHALL have no effect.
REQ-023 Idle timer: 16-bit; SHALL count in FILL while the word count is >0 and no word is accepted; SHALL clear on accept, on entering PEND, and while the count is 0.
REQ-024 wr_en SHALL be combinational: (state==PEND) & ~almost_full.
REQ-025 dout SHALL be driven from registers and SHALL be stable throughout PEND.
REQ-026 In a PEND cycle with wr_en=1, at the clock edge the block SHALL clear the word count, valid mask, types and slot registers, increment pkt_count, and return to FILL.
REQ-027 While almost_full=1, PEND SHALL hold indefinitely with no data loss.
REQ-028 Latency: wr_en SHALL assert in the cycle immediately after the edge that accepted the 7th word, when almost_full=0.
REQ-029 Peak throughput: one packet per 8 cycles (7 accepts plus 1 emit).
REQ-030 pkt_count SHALL wrap modulo 2^32.
REQ-031 wr_en SHALL never be asserted for an empty packet.

Reset
REQ-032 While rst=1, state SHALL be FILL and the word count, timer, slots, mask, types and pkt_count SHALL be 0.
REQ-033 While rst=1, outputs SHALL be: din_ready=0, wr_en=0, dout=0.
REQ-034 Reset asserted mid-fill or in PEND SHALL discard the partial or pending packet, and no write SHALL occur.

Verification
REQ-035 Stream 7 words 0x1..0x7, type 2'b01, almost_full=0 -> one wr_en pulse the next cycle; dout[223:0] holds the words in slot order; dout[255:224]=0xE01F_D555; pkt_count=1.
REQ-036 3 words then idle, TIMEOUT=4 -> after 4 idle cycles wr_en pulses once; valid mask=3'b111 (status 0xE001_C000 | types); slots 3..6 zero.
REQ-037 7 words with almost_full=1 held 20 cycles -> din_ready=0 and wr_en=0 for 20 cycles; wr_en pulses exactly once after release with unchanged dout.
REQ-038 flush with count 0 -> no wr_en; flush coincident with the 2nd accept -> no emission until a later flush or timeout, then valid mask=2'b11.
REQ-039 rst pulsed after 5 accepted words -> no wr_en; the next 7 words form a clean packet with pkt_count=1.
REQ-040 Back-to-back continuous din_valid for 70 words -> exactly 10 packets, each wr_en one cycle wide, with no word lost or duplicated.
